// File: rtl/note_tone_gen.sv
// Song-ROM note decoder and square-wave speaker driver. Pitch changes are deferred
// to a waveform edge; reloading the code already in effect keeps the phase running.
module note_tone_gen #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned CNT_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        note_load,
    input  logic [11:0] note_code,
    output logic        spk,
    output logic        note_active,
    output logic        note_err,
    output logic [11:0] cur_code
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;
    typedef enum logic [1:0] {KindRest, KindNote, KindIllegal} kind_e;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [20:0][CNT_W-1:0] tab_t;

    // Index = octave * 7 + (degree - 1), octave 0 = low nibble.
    function automatic int unsigned freq_of(int unsigned idx);
        case (idx)
            0:       return 262;
            1:       return 294;
            2:       return 330;
            3:       return 349;
            4:       return 392;
            5:       return 440;
            6:       return 494;
            7:       return 523;
            8:       return 587;
            9:       return 659;
            10:      return 698;
            11:      return 784;
            12:      return 880;
            13:      return 988;
            14:      return 1046;
            15:      return 1175;
            16:      return 1318;
            17:      return 1397;
            18:      return 1568;
            19:      return 1760;
            20:      return 1976;
            default: return 262;
        endcase
    endfunction

    function automatic tab_t build_tab();
        tab_t t;
        t = '0;
        for (int unsigned i = 0; i < 21; i++) begin
            t[5'(i)] = cnt_t'(CLK_HZ / (2 * freq_of(i)));
        end
        return t;
    endfunction

    localparam tab_t HalfTab = build_tab();

    function automatic kind_e kind_of(logic [11:0] c);
        logic [1:0] nz;
        logic       big;
        nz  = 2'd0;
        big = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (c[4*i +: 4] != 4'd0) nz = nz + 2'd1;
            if (c[4*i+3]) big = 1'b1;
        end
        if (nz == 2'd0) return KindRest;
        if (nz == 2'd1 && !big) return KindNote;
        return KindIllegal;
    endfunction

    function automatic cnt_t half_of(logic [11:0] c);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 3; i++) begin
            if (c[4*i +: 4] != 4'd0) idx = 5'(7 * i) + {1'b0, c[4*i +: 4]} - 5'd1;
        end
        if (kind_of(c) != KindNote || idx > 5'd20) return '0;
        return HalfTab[idx];
    endfunction

    state_e      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    cnt_t        half_q, half_d;
    cnt_t        pend_half_q, pend_half_d;
    logic        spk_q, spk_d;
    logic        act_q, act_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;
    logic [11:0] cur_q, cur_d;
    logic [11:0] pend_code_q, pend_code_d;

    logic        load_same, load_new, terminal;
    logic        mrg_pend;
    logic [11:0] mrg_code;
    cnt_t        mrg_half;

    // A load matching what would take effect next is a sustain, not a change.
    assign load_same = pend_q ? (note_code == pend_code_q) : (note_code == cur_q);
    assign load_new  = note_load && !load_same;
    assign terminal  = (cnt_q == half_q - cnt_t'(1));

    // Pending view after this cycle's load; terminal-count logic sees it directly.
    assign mrg_pend = load_new | pend_q;
    assign mrg_code = load_new ? note_code : pend_code_q;
    assign mrg_half = load_new ? half_of(note_code) : pend_half_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        spk_d       = spk_q;
        act_d       = act_q;
        cur_d       = cur_q;
        err_d       = err_q | (note_load && kind_of(note_code) == KindIllegal);
        pend_d      = mrg_pend;
        pend_code_d = mrg_code;
        pend_half_d = mrg_half;

        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
            spk_d   = 1'b0;
            act_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    spk_d = 1'b0;
                    if (pend_q) begin
                        cur_d = pend_code_q;
                        if (!load_new) pend_d = 1'b0;
                        if (kind_of(pend_code_q) == KindNote) begin
                            state_d = StRun;
                            half_d  = pend_half_q;
                            act_d   = 1'b1;
                        end
                    end else if (!load_new && kind_of(cur_q) == KindNote) begin
                        // Only reachable after en was low: replay the held note.
                        pend_d      = 1'b1;
                        pend_code_d = cur_q;
                        pend_half_d = half_of(cur_q);
                    end
                end
                StRun: begin
                    cnt_d = cnt_q + cnt_t'(1);
                    if (terminal) begin
                        cnt_d = '0;
                        if (mrg_pend) begin
                            pend_d = 1'b0;
                            cur_d  = mrg_code;
                            if (kind_of(mrg_code) == KindNote) begin
                                half_d = mrg_half;
                                spk_d  = ~spk_q;
                            end else begin
                                spk_d   = 1'b0;
                                act_d   = 1'b0;
                                state_d = StIdle;
                            end
                        end else begin
                            spk_d = ~spk_q;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            half_q      <= '0;
            pend_half_q <= '0;
            spk_q       <= 1'b0;
            act_q       <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            cur_q       <= '0;
            pend_code_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            pend_half_q <= pend_half_d;
            spk_q       <= spk_d;
            act_q       <= act_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            cur_q       <= cur_d;
            pend_code_q <= pend_code_d;
        end
    end

    assign spk         = spk_q;
    assign note_active = act_q;
    assign note_err    = err_q;
    assign cur_code    = cur_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: directed waveform-timing scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the note player.
module tb_note_tone_gen;

    localparam int unsigned CLK_HZ = 26200;
    localparam int unsigned CNT_W  = 8;
    localparam int FREQ [21] = '{262, 294, 330, 349, 392, 440, 494,
                                 523, 587, 659, 698, 784, 880, 988,
                                 1046, 1175, 1318, 1397, 1568, 1760, 1976};
    localparam logic [11:0] POOL [8] = '{12'h001, 12'h005, 12'h010, 12'h100,
                                         12'h107, 12'h000, 12'h130, 12'h008};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        note_load = 1'b0;
    logic [11:0] note_code = '0;
    logic        spk, note_active, note_err;
    logic [11:0] cur_code;

    note_tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .note_load  (note_load),
        .note_code  (note_code),
        .spk        (spk),
        .note_active(note_active),
        .note_err   (note_err),
        .cur_code   (cur_code)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   edges[$];
    logic spk_prev = 1'b0;

    // Reference model: what the player should be doing, in beat/half-period terms.
    logic        m_spk, m_act, m_err, m_playing, m_has_pend;
    logic [11:0] m_cur, m_pend;
    int          m_half, m_elapsed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // 0 = rest, 1 = note, 2 = illegal
    function automatic int code_kind(logic [11:0] c);
        int nz = 0;
        int bad = 0;
        for (int i = 0; i < 3; i++) begin
            int d = (int'(c) / (16 ** i)) % 16;
            if (d != 0) nz++;
            if (d > 7) bad = 1;
        end
        if (nz == 0) return 0;
        if (nz == 1 && bad == 0) return 1;
        return 2;
    endfunction

    function automatic int code_half(logic [11:0] c);
        for (int i = 0; i < 3; i++) begin
            int d = (int'(c) / (16 ** i)) % 16;
            if (d >= 1 && d <= 7) return int'(CLK_HZ) / (2 * FREQ[i * 7 + d - 1]);
        end
        return 0;
    endfunction

    task automatic model_step();
        logic        had_pend;
        logic [11:0] old_pend;
        logic        fresh;
        if (rst) begin
            m_spk = 0; m_act = 0; m_err = 0; m_cur = '0; m_pend = '0;
            m_has_pend = 0; m_playing = 0; m_elapsed = 0; m_half = 0;
            return;
        end
        had_pend = m_has_pend;
        old_pend = m_pend;
        fresh    = 0;
        if (note_load) begin
            if (code_kind(note_code) == 2) m_err = 1;
            if (m_has_pend ? (note_code != m_pend) : (note_code != m_cur)) begin
                m_has_pend = 1; m_pend = note_code; fresh = 1;
            end
        end
        if (!en) begin
            m_playing = 0; m_spk = 0; m_act = 0; m_elapsed = 0;
        end else if (!m_playing) begin
            if (had_pend) begin
                m_cur = old_pend;
                if (!fresh) m_has_pend = 0;
                if (code_kind(old_pend) == 1) begin
                    m_playing = 1; m_elapsed = 0; m_half = code_half(old_pend); m_act = 1;
                end
            end else if (!m_has_pend && code_kind(m_cur) == 1) begin
                m_has_pend = 1; m_pend = m_cur;
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == m_half) begin
                m_elapsed = 0;
                if (m_has_pend) begin
                    m_has_pend = 0;
                    m_cur = m_pend;
                    if (code_kind(m_pend) == 1) begin
                        m_half = code_half(m_pend); m_spk = !m_spk;
                    end else begin
                        m_spk = 0; m_act = 0; m_playing = 0;
                    end
                end else begin
                    m_spk = !m_spk;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (spk !== spk_prev) edges.push_back(cyc);
        spk_prev = spk;
        check_eq("spk", 32'(spk), 32'(m_spk));
        check_eq("note_active", 32'(note_active), 32'(m_act));
        check_eq("note_err", 32'(note_err), 32'(m_err));
        check_eq("cur_code", 32'(cur_code), 32'(m_cur));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [11:0] c);
        note_code = c;
        note_load = 1'b1;
        tick();
        note_load = 1'b0;
    endtask

    task automatic pad_edges(input int n);
        while (edges.size() < n) edges.push_back(-100000);
    endtask

    function automatic logic [11:0] pick_code();
        int s = $urandom_range(0, 9);
        if (s < 7) return POOL[$urandom_range(0, 7)];
        if (s == 7) return m_cur;
        if (s == 8) return m_pend;
        return 12'($urandom);
    endfunction

    initial begin
        int c_apply, t_load, j, en_off;

        // Reset, then reset again in the middle of a tone.
        rst = 1; ticks(3); rst = 0; en = 1;
        check_eq("rst_spk", 32'(spk), 0);
        check_eq("rst_active", 32'(note_active), 0);
        check_eq("rst_cur", 32'(cur_code), 0);
        load(12'h010); ticks(80);
        rst = 1; tick();
        check_eq("midrst_spk", 32'(spk), 0);
        check_eq("midrst_active", 32'(note_active), 0);
        check_eq("midrst_err", 32'(note_err), 0);
        check_eq("midrst_cur", 32'(cur_code), 0);
        ticks(2); rst = 0;
        edges.delete(); ticks(100);
        check_eq("midrst_quiet", edges.size(), 0);

        // Middle do from idle: active two cycles after the load, 25/25 waveform.
        load(12'h010);
        check_eq("t2_act_early", 32'(note_active), 0);
        tick();
        check_eq("t2_act", 32'(note_active), 1);
        c_apply = cyc;
        edges.delete(); ticks(200);
        pad_edges(3);
        check_eq("t2_first_rise", edges[0] - c_apply, 25);
        check_eq("t2_high", edges[1] - edges[0], 25);
        check_eq("t2_period", edges[2] - edges[0], 50);

        // Held low sol: reloads must not restart the phase.
        rst = 1; tick(); rst = 0;
        load(12'h005); tick();
        edges.delete();
        ticks(199); load(12'h005); ticks(199); load(12'h005); ticks(199);
        pad_edges(2);
        for (int i = 1; i < edges.size(); i++) check_eq("t3_half", edges[i] - edges[i-1], 33);
        check_eq("t3_cur", 32'(cur_code), 32'h005);

        // Switch to low do mid half-period: old half finishes, then 50-cycle halves.
        ticks(10);
        load(12'h001);
        t_load = cyc;
        ticks(400);
        j = -1;
        for (int i = 0; i < edges.size(); i++) if (j < 0 && edges[i] >= t_load) j = i;
        check_eq("t4_found", 32'(j >= 1), 1);
        if (j >= 1) begin
            check_eq("t4_old_half", edges[j] - edges[j-1], 33);
            for (int k = j + 1; k < edges.size(); k++)
                check_eq("t4_new_half", edges[k] - edges[k-1], 50);
        end
        check_eq("t4_cur", 32'(cur_code), 32'h001);

        // Rest, then an illegal code: muted, sticky error.
        load(12'h000); ticks(60);
        check_eq("t5_spk", 32'(spk), 0);
        check_eq("t5_active", 32'(note_active), 0);
        check_eq("t5_cur", 32'(cur_code), 0);
        load(12'h130); ticks(3);
        check_eq("t5_err", 32'(note_err), 1);
        check_eq("t5_cur_illegal", 32'(cur_code), 32'h130);
        edges.delete(); ticks(100);
        check_eq("t5_err_sticky", 32'(note_err), 1);
        check_eq("t5_quiet", edges.size(), 0);

        // Enable pulse low: immediate mute, then a clean restart.
        rst = 1; tick(); rst = 0;
        load(12'h010); ticks(100);
        en = 0; tick();
        check_eq("t6_mute", 32'(spk), 0);
        check_eq("t6_inactive", 32'(note_active), 0);
        ticks(9);
        en = 1; tick();
        c_apply = cyc;
        edges.delete(); ticks(60);
        pad_edges(1);
        check_eq("t6_restart", edges[0] - c_apply, 26);
        check_eq("t6_cur", 32'(cur_code), 32'h010);

        // Randomized traffic: loads, repeats, illegal codes, enable drops, resets.
        rst = 1; tick(); rst = 0; en = 1;
        en_off = 0;
        for (int n = 0; n < 6000; n++) begin
            int r = $urandom_range(0, 999);
            rst = (r < 2);
            if (en_off > 0) begin
                en = 0;
                en_off--;
            end else begin
                en = 1;
                if (r >= 2 && r < 6) en_off = $urandom_range(1, 15);
            end
            note_load = ($urandom_range(0, 29) == 0);
            note_code = pick_code();
            tick();
        end
        rst = 0; en = 1; note_load = 0;
        ticks(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
